timing3: RTL

- Parametrised successor to the fixed 8-slot bus sequencer.
- Divides the 16 MHz system clock into 2-cycle bus slots and rotates bus ownership round-robin over NUM_SLOTS slots per frame.
- Generates registered enables for the SPI master, video RAM/ROM fetch and the 6502, plus the CPU clock.
- Adds configurable slot mapping, a runtime CPU frame divider (CPU speed select), registered SPI handshake timing, and an optional idle-slot borrow for SPI.

---
 rtl/timing3.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/timing3.sv
// timing3 - bus slot sequencer for the 16 MHz system clock.
//
// Each bus slot is two clk_16_i cycles (phase 0, phase 1); NUM_SLOTS slots
// make a frame and bus ownership rotates round-robin through them. All
// enables are registered, change only on slot boundaries and are held for
// both cycles of their slot. Inputs that steer a slot are taken from the
// last cycle (phase 1) of the slot before it.
//
// A 4-bit frame counter runs 0..div, with div taken from cpu_div_i at each
// frame boundary; only the frame where counter == div grants the CPU.
//
// Optional build macro: TIMING3_SPI_BORROW_EN
//   defined   - CPU_SLOT of a frame without a CPU grant serves SPI instead
//   undefined - that slot stays idle
//
//   phase | meaning
//   0     | first half of a slot, clk_8_o low
//   1     | second half, clk_8_o high, inputs sampled for the next slot

module timing3 #(
    parameter int                   NUM_SLOTS       = 8,
    parameter logic [NUM_SLOTS-1:0] SPI_SLOT_MASK   = {{(NUM_SLOTS-1){1'b0}}, 1'b1},
    parameter int                   VIDEO_RAM_SLOT  = 1,
    parameter int                   VIDEO_ROM_SLOT  = 2,
    parameter int                   CPU_SLOT        = NUM_SLOTS - 1,
    parameter int                   CPU_SELECT_LEAD = 1
) (
    input  logic                         clk_16_i,
    input  logic                         reset_n_i,
    output logic                         clk_8_o,
    output logic                         clk_cpu_o,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_o,
    input  logic [3:0]                   cpu_div_i,
    input  logic                         spi_valid_i,
    output logic                         spi_enable_o,
    output logic                         spi_ready_o,
    output logic                         video_ram_enable_o,
    output logic                         video_rom_enable_o,
    input  logic                         cpu_valid_i,
    output logic                         cpu_select_o,
    output logic                         cpu_enable_o
);

    localparam int SW   = $clog2(NUM_SLOTS);
    localparam int NPOW = 1 << SW;

    // Slot lookup tables padded to a power of two so any slot index is legal.
    function automatic logic [NPOW-1:0] range_mask(input int lo, input int hi);
        logic [NPOW-1:0] m;
        m = '0;
        for (int i = 0; i < NPOW; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [NPOW-1:0] spi_map();
        logic [NPOW-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m[i] = SPI_SLOT_MASK[i];
        end
        return m;
    endfunction

    localparam logic [NPOW-1:0] RAM_M = range_mask(VIDEO_RAM_SLOT, VIDEO_RAM_SLOT);
    localparam logic [NPOW-1:0] ROM_M = range_mask(VIDEO_ROM_SLOT, VIDEO_ROM_SLOT);
    localparam logic [NPOW-1:0] CPU_M = range_mask(CPU_SLOT, CPU_SLOT);
    localparam logic [NPOW-1:0] WIN_M = range_mask(CPU_SLOT - CPU_SELECT_LEAD, CPU_SLOT);
    localparam logic [NPOW-1:0] SPI_M = spi_map();

    localparam logic [SW-1:0] LAST  = SW'(NUM_SLOTS - 1);
    localparam bit            LEAD0 = (CPU_SELECT_LEAD == 0);

    // Reject slot maps that would hand one slot to two owners.
    if (NUM_SLOTS < 4 || NUM_SLOTS > 16) begin : g_err_num
        $error("timing3: NUM_SLOTS must be within 4..16");
    end
    if (VIDEO_RAM_SLOT < 0 || VIDEO_RAM_SLOT >= NUM_SLOTS ||
        VIDEO_ROM_SLOT < 0 || VIDEO_ROM_SLOT >= NUM_SLOTS ||
        CPU_SLOT < 0 || CPU_SLOT >= NUM_SLOTS) begin : g_err_range
        $error("timing3: slot index out of range");
    end
    if (CPU_SELECT_LEAD < 0 || CPU_SELECT_LEAD > CPU_SLOT) begin : g_err_lead
        $error("timing3: CPU_SELECT_LEAD must be within 0..CPU_SLOT");
    end
    if ((RAM_M & ROM_M) != '0 || (RAM_M & CPU_M) != '0 || (ROM_M & CPU_M) != '0) begin : g_err_ovl
        $error("timing3: video and CPU slots overlap");
    end
    if ((SPI_M & (RAM_M | ROM_M | CPU_M)) != '0) begin : g_err_spi
        $error("timing3: SPI_SLOT_MASK overlaps a video or CPU slot");
    end
    if (((RAM_M | ROM_M) & WIN_M) != '0) begin : g_err_win
        $error("timing3: CPU select window overlaps a video slot");
    end

    logic          phase_q;
    logic [3:0]    frame_cnt_q;
    logic [3:0]    div_q;

    logic          frame_end;
    logic [SW-1:0] slot_nxt;
    logic [3:0]    cnt_nxt;
    logic [3:0]    div_nxt;
    logic          active_nxt;
    logic          spi_nxt;
    logic          sel_nxt;
    logic          en_nxt;

    // Next-slot decode: everything here is only consumed on phase 1 edges.
    always_comb begin
        frame_end = phase_q && (slot_o == LAST);
        slot_nxt  = (slot_o == LAST) ? '0 : slot_o + SW'(1);
        div_nxt   = div_q;
        cnt_nxt   = frame_cnt_q;
        if (frame_end) begin
            div_nxt = cpu_div_i;
            cnt_nxt = (frame_cnt_q >= cpu_div_i) ? 4'd0 : frame_cnt_q + 4'd1;
        end
        active_nxt = (cnt_nxt == div_nxt);
`ifdef TIMING3_SPI_BORROW_EN
        spi_nxt = spi_valid_i & (SPI_M[slot_nxt] | (CPU_M[slot_nxt] & ~active_nxt));
`else
        spi_nxt = spi_valid_i & SPI_M[slot_nxt];
`endif
        sel_nxt = active_nxt & WIN_M[slot_nxt] & cpu_valid_i;
        // With a lead the grant is committed by the select of the slot before,
        // so a late drop of cpu_valid_i cannot cancel a started access.
        if (LEAD0) en_nxt = CPU_M[slot_nxt] & sel_nxt;
        else       en_nxt = CPU_M[slot_nxt] & cpu_select_o;
    end

    // Phase, slot and frame counters.
    always_ff @(posedge clk_16_i) begin
        if (!reset_n_i) begin
            phase_q     <= 1'b0;
            slot_o      <= '0;
            frame_cnt_q <= 4'd0;
            div_q       <= 4'd0;
        end else begin
            phase_q <= ~phase_q;
            if (phase_q) begin
                slot_o      <= slot_nxt;
                frame_cnt_q <= cnt_nxt;
                div_q       <= div_nxt;
            end
        end
    end

    // Slot-rate enables, loaded on the last edge of each slot.
    always_ff @(posedge clk_16_i) begin
        if (!reset_n_i) begin
            spi_enable_o       <= 1'b0;
            spi_ready_o        <= 1'b0;
            video_ram_enable_o <= 1'b0;
            video_rom_enable_o <= 1'b0;
            cpu_select_o       <= 1'b0;
            cpu_enable_o       <= 1'b0;
        end else if (phase_q) begin
            spi_enable_o       <= spi_nxt;
            spi_ready_o        <= spi_enable_o;
            video_ram_enable_o <= RAM_M[slot_nxt];
            video_rom_enable_o <= ROM_M[slot_nxt];
            cpu_select_o       <= sel_nxt;
            cpu_enable_o       <= en_nxt;
        end
    end

    // Bus clock and PHI2, registered so neither can glitch.
    always_ff @(posedge clk_16_i) begin
        if (!reset_n_i) begin
            clk_8_o   <= 1'b0;
            clk_cpu_o <= 1'b0;
        end else begin
            clk_8_o   <= ~phase_q;
            clk_cpu_o <= ~phase_q & cpu_enable_o;
        end
    end

endmodule
